id_issue_ctrl: RTL

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

---
 rtl/id_issue_ctrl_pkg.sv | 26 ++
 rtl/id_scoreboard.sv | 53 +++++
 rtl/id_issue_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared parameters for the ID-stage issue controller: FSM encodings, depth
// default and the base-ISA opcodes the decoder feeds into the controller.
package id_issue_ctrl_pkg;

  localparam int MAX_INFLIGHT_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } issue_state_e;

  // Opcodes whose rs1/rs2 fields are not read by the decoder (LUI, AUIPC, JAL)
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/id_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register,
// with write-back bypass on the lookup side.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  input  logic [4:0]  rd_idx,
  output logic [31:0] busy,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rd_busy,
  output logic        clr_err
);

  logic [31:0] busy_q;
  logic [31:0] eff_busy;
  logic [31:0] busy_nxt;

  // A register being written back this cycle no longer blocks a reader.
  always_comb begin
    eff_busy = busy_q;
    if (clr_en) eff_busy[clr_idx] = 1'b0;
    eff_busy[0] = 1'b0;
  end

  assign rs1_busy = eff_busy[rs1_idx];
  assign rs2_busy = eff_busy[rs2_idx];
  assign rd_busy  = eff_busy[rd_idx];
  assign clr_err  = clr_en && (clr_idx != 5'd0) && !busy_q[clr_idx];

  // Set is applied after clear so a new writer wins over a same-cycle WB.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_en && clr_idx != 5'd0) busy_nxt[clr_idx] = 1'b0;
    if (set_en && set_idx != 5'd0) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy = busy_q;

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: hazard/serialisation gating, in-flight counter,
// RUN/STALL/DRAIN sequencing and sticky protocol-error flag.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_rs1_used,
  input  logic        i_rs2_used,
  input  logic        i_rd_wr,
  input  logic        i_fence,
  input  logic        i_ex_ready,
  input  logic        i_flush,
  input  logic        i_wb_wr,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_retire,
  output logic        o_issue,
  output logic        o_id_stall,
  output logic [31:0] o_busy,
  output logic [2:0]  o_inflight,
  output logic [1:0]  o_state,
  output logic        o_sb_err
);

  // state    | meaning
  // ST_RUN   | normal issue
  // ST_STALL | ID instruction held by hazard, depth or EX back-pressure
  // ST_DRAIN | fence waiting for all older instructions and writes to finish

  issue_state_e state_q, state_nxt;
  logic [2:0]   inflight_q;
  logic         err_q;
  logic         rs1_busy, rs2_busy, rd_busy, clr_err;
  logic         hazard, below_max, fence_block, drain_ok, issue, stall;

  id_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue & i_rd_wr),
    .set_idx  (i_rd),
    .clr_en   (i_wb_wr),
    .clr_idx  (i_wb_rd),
    .rs1_idx  (i_rs1),
    .rs2_idx  (i_rs2),
    .rd_idx   (i_rd),
    .busy     (o_busy),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .clr_err  (clr_err)
  );

  assign hazard      = (i_rs1_used & rs1_busy) | (i_rs2_used & rs2_busy) | (i_rd_wr & rd_busy);
  assign below_max   = inflight_q < 3'(MAX_INFLIGHT);
  assign fence_block = i_fence && (inflight_q != 3'd0);
  assign drain_ok    = (state_q != ST_DRAIN) || ((inflight_q == 3'd0) && (o_busy == 32'd0));

  // rst gating keeps issue/stall quiet while the async reset is held.
  assign issue = !rst && i_dec_valid && !i_flush && !hazard && i_ex_ready &&
                 below_max && !fence_block && drain_ok;
  assign stall = !rst && i_dec_valid && !i_flush && !issue;

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (stall) state_nxt = i_fence ? ST_DRAIN : ST_STALL;
      end
      ST_STALL: begin
        if (issue || !i_dec_valid) state_nxt = ST_RUN;
        else if (stall && i_fence) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (issue) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
    if (i_flush) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      inflight_q <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (issue && !i_retire)
        inflight_q <= inflight_q + 3'd1;
      else if (!issue && i_retire && inflight_q != 3'd0)
        inflight_q <= inflight_q - 3'd1;
      if (clr_err || (i_retire && inflight_q == 3'd0))
        err_q <= 1'b1;
    end
  end

  assign o_issue    = issue;
  assign o_id_stall = stall;
  assign o_inflight = inflight_q;
  assign o_state    = state_q;
  assign o_sb_err   = err_q;

endmodule
